data_memory_mp: RTL and testbench
=================================

# data_memory_mp

Parametrised multi-port data memory for the pipeline's execute/memory stage, replacing the fixed four-read/four-write, 16-bit memory. Read and write port counts, data width and address width are parameters. Reads are registered with a valid flag, writes take per-byte enables, and simultaneous same-address writes resolve by fixed priority with a conflict flag. After reset, a built-in sequencer zeroes every word before the memory accepts traffic.

## Interface
- NUM_RD, default 4: number of read ports (1..8).
- NUM_WR, default 4: number of write ports (1..8).
- DATA_W, default 16: word width in bits; must be a multiple of 8.
- ADDR_W, default 10: address width; DEPTH = 2**ADDR_W words.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, registered.
- rd_valid  out  NUM_RD  rd_data for port i is valid this cycle.
- wr_en  in  NUM_WR  per-port write request.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- wr_be  in  NUM_WR*(DATA_W/8)  per-port byte enables; bit b selects byte b.
- wr_conflict  out  1  registered pulse: two or more enabled writes hit the same address and at least one shared byte.
- busy  out  1  clear sequence is in progress; all requests are ignored.

## Operation
- State machine has two states, CLEAR and READY. Reset forces CLEAR with clear pointer = 0.
- CLEAR: each cycle writes 0 to mem[ptr], then increments ptr. When ptr = DEPTH-1 is written, the FSM moves to READY on the next edge. busy = 1 throughout CLEAR.
- CLEAR: rd_en and wr_en are ignored. rd_valid stays 0 and memory contents are untouched except by the clear writes.
- Reset asserted mid-CLEAR restarts the sequence at ptr = 0.
- READY: each enabled write port updates only the bytes selected by wr_be. Byte enable 0 on every bit is a no-op.
- Priority: for each byte of an address written by several ports in one cycle, the highest-index enabled port wins. wr_conflict is 1 in the following cycle.
- Read: rd_en[i] at cycle N captures mem[rd_addr[i]] into rd_data[i] and sets rd_valid[i] = 1 at N+1.
- Read with rd_en[i] = 0: rd_valid[i] = 0 next cycle and rd_data[i] holds its previous value.
- Several read ports may read the same address in the same cycle with no interaction.
- Addresses are ADDR_W wide, so there is no out-of-range case.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, wr_conflict = 0, busy = 1.
- Clear length is DEPTH cycles after reset deasserts. busy falls at the edge ending cycle DEPTH, and the first request is accepted in the cycle busy reads 0.
- Read latency is 1 cycle. Write data is visible to reads issued in the following cycle.
- Read and write to the same address in the same cycle: behaviour is set by configuration (below).
- Throughput: every port can issue one operation per cycle.

## Configuration
- DATA_MEMORY_BYPASS_EN defined: a same-cycle same-address read returns the post-write word. That word is the priority-merged result of all enabled writes to that address, per byte; bytes not written come from memory.
- DATA_MEMORY_BYPASS_EN undefined: a same-cycle same-address read returns the pre-write word (read-old).

## Structure
- Package data_memory_pkg holds:
  - default parameter constants (NUM_RD, NUM_WR, DATA_W, ADDR_W);
  - the state typedef enum {CLEAR, READY};
  - localparam BYTES = DATA_W/8.
- Sub-module data_memory_wr_merge: given one target address, it produces the priority-merged byte-enable and data for all write ports plus a conflict bit. It is instantiated per write port for storage, and per read port for bypass when DATA_MEMORY_BYPASS_EN is set. The top module holds the array, FSM and output registers.

## Test plan
- Reset, then count cycles -> busy = 1 for exactly DEPTH (1024) cycles; a write issued during CLEAR has no effect; a read of addr 0x3FF after busy falls returns 0x0000 with rd_valid = 1.
- Port 0 writes 0xABCD to addr 5 (wr_be = 2'b11); next cycle ports 0..3 all read addr 5 -> each rd_data = 0xABCD one cycle later with rd_valid = 1.
- Same cycle, port 1 writes 0x1111 (be = 11) and port 3 writes 0x22xx (be = 10) to addr 7 -> mem[7] = 0x2211 and wr_conflict = 1 for one cycle.
- Port 2 writes 0x5A5A to addr 9 while port 0 reads addr 9 in the same cycle (old value 0x0000) -> rd_data = 0x5A5A with bypass defined, 0x0000 without.
- Assert reset at clear pointer 500, hold one cycle -> pointer restarts at 0 and busy lasts a further 1024 cycles. Also write 0xBEEF to addr 3 in READY, then reset -> addr 3 reads 0x0000 after the clear.
- NUM_RD = 1, NUM_WR = 2, DATA_W = 32 build -> byte-enable write of 0x000000FF with be = 0001 to addr 1 (old 0x12345678) reads back 0x123456FF.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared defaults, state type and byte-count constant for the multi-port data memory.
package data_memory_pkg;

  localparam int unsigned DEF_NUM_RD = 4;
  localparam int unsigned DEF_NUM_WR = 4;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 10;

  localparam int unsigned BYTES = DEF_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/data_memory_wr_merge.sv
// Priority merge of all write ports against one target address: highest enabled port wins
// each byte; conflict flags any byte claimed by more than one port.
module data_memory_wr_merge
  import data_memory_pkg::*;
#(
  parameter int unsigned NUM_WR = DEF_NUM_WR,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         enable,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  input  logic [NUM_WR*(DATA_W/8)-1:0] wr_be,
  output logic [DATA_W/8-1:0]          merged_be,
  output logic [DATA_W-1:0]            merged_data,
  output logic                         conflict
);

  localparam int unsigned NB = DATA_W / 8;

  always_comb begin
    merged_be   = '0;
    merged_data = '0;
    conflict    = 1'b0;
    // ascending scan so the last (highest-index) hit overwrites earlier ones
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (enable && wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (wr_be[p*NB + b]) begin
            if (merged_be[b]) conflict = 1'b1;
            merged_be[b]            = 1'b1;
            merged_data[b*8 +: 8]   = wr_data[p*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_memory_mp.sv
// Multi-port data memory with post-reset clear sequencer, byte-enabled priority writes and
// registered reads. Define DATA_MEMORY_BYPASS_EN for write-to-read bypass (else read-old).
module data_memory_mp
  import data_memory_pkg::*;
#(
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned NUM_WR = DEF_NUM_WR,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  input  logic [NUM_WR*(DATA_W/8)-1:0] wr_be,
  output logic                         wr_conflict,
  output logic                         busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              ready;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [NB-1:0]     st_be   [NUM_WR];
  logic [DATA_W-1:0] st_data [NUM_WR];
  logic [NUM_WR-1:0] st_conf;
  logic [DATA_W-1:0] rd_word [NUM_RD];
  logic              conf_any;

  assign ready = (state == READY);
  assign busy  = (state == CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == '1) state <= READY;
    end
  end

  // every write port stores the fully merged word for its address, so ports sharing an
  // address all write identical bytes
  for (genvar wp = 0; wp < NUM_WR; wp++) begin : g_st
    data_memory_wr_merge #(
      .NUM_WR (NUM_WR),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_st_merge (
      .addr        (wr_addr[wp*ADDR_W +: ADDR_W]),
      .enable      (ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .merged_be   (st_be[wp]),
      .merged_data (st_data[wp]),
      .conflict    (st_conf[wp])
    );
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (st_be[p][b]) mem[wr_addr[p*ADDR_W +: ADDR_W]][b*8 +: 8] <= st_data[p][b*8 +: 8];
        end
      end
    end
  end

`ifdef DATA_MEMORY_BYPASS_EN
  logic [NB-1:0]     byp_be   [NUM_RD];
  logic [DATA_W-1:0] byp_data [NUM_RD];
  logic [NUM_RD-1:0] byp_conf;

  for (genvar rp = 0; rp < NUM_RD; rp++) begin : g_byp
    data_memory_wr_merge #(
      .NUM_WR (NUM_WR),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_byp_merge (
      .addr        (rd_addr[rp*ADDR_W +: ADDR_W]),
      .enable      (ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .merged_be   (byp_be[rp]),
      .merged_data (byp_data[rp]),
      .conflict    (byp_conf[rp])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_word[r] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
      for (int unsigned b = 0; b < NB; b++) begin
        if (byp_be[r][b]) rd_word[r][b*8 +: 8] = byp_data[r][b*8 +: 8];
      end
    end
  end

  // a bypass-side conflict implies the same conflict on the storage side, so OR-ing it in
  // leaves wr_conflict unchanged
  assign conf_any = (|st_conf) | (|byp_conf);
`else
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_word[r] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
    end
  end

  assign conf_any = |st_conf;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data     <= '0;
      rd_valid    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_RD; r++) begin
        rd_valid[r] <= ready && rd_en[r];
        if (ready && rd_en[r]) rd_data[r*DATA_W +: DATA_W] <= rd_word[r];
      end
      wr_conflict <= conf_any;
    end
  end

endmodule

// File: tb/tb_data_memory_mp.sv
// Bench for data_memory_mp: directed table, hand sequences and randomized traffic against
// an array-based reference model; also a 32-bit, 1-read/2-write instance.
module tb_data_memory_mp;

  localparam int NR = 4, NW = 4, DW = 16, AW = 10, NB = 2;

`ifdef DATA_MEMORY_BYPASS_EN
  localparam logic [15:0] BYP9 = 16'h5A5A;
  localparam logic [15:0] BYP20 = 16'h4000;
`else
  localparam logic [15:0] BYP9 = 16'h0000;
  localparam logic [15:0] BYP20 = 16'h0000;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW*NB-1:0] wr_be;
  logic             wr_conflict, busy;

  logic [0:0]  rd_en2;
  logic [9:0]  rd_addr2;
  logic [31:0] rd_data2;
  logic [0:0]  rd_valid2;
  logic [1:0]  wr_en2;
  logic [19:0] wr_addr2;
  logic [63:0] wr_data2;
  logic [7:0]  wr_be2;
  logic        wr_conflict2, busy2;

  data_memory_mp #(.NUM_RD(NR), .NUM_WR(NW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_conflict(wr_conflict), .busy(busy)
  );

  data_memory_mp #(.NUM_RD(1), .NUM_WR(2), .DATA_W(32), .ADDR_W(10)) dut32 (
    .clock(clock), .reset(reset), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_be(wr_be2),
    .wr_conflict(wr_conflict2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mm [1024];
  logic [15:0] exp_rd [NR];

  typedef struct {
    string            name;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic [NW*NB-1:0] wbe;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] xd;
    logic [NR-1:0]    xv;
    logic             xc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en2 = '0; rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; wr_be2 = '0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < 1024; a++) mm[a] = '0;
    for (int i = 0; i < NR; i++) exp_rd[i] = '0;
  endtask

  function automatic logic [NR*AW-1:0] pa(input logic [AW-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [NR*DW-1:0] pd(input logic [DW-1:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  // Apply the currently driven inputs for one READY cycle and check against the model.
  task automatic step();
    logic [15:0] nexp [NR];
    logic [NR-1:0] nval;
    logic nconf;
    logic [15:0] w;
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*AW +: AW];
      w = mm[a];
`ifdef DATA_MEMORY_BYPASS_EN
      for (int p = 0; p < NW; p++)
        for (int b = 0; b < NB; b++)
          if (wr_en[p] && wr_addr[p*AW +: AW] == a && wr_be[p*NB + b])
            w[b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
`endif
      nval[i] = rd_en[i];
      nexp[i] = rd_en[i] ? w : exp_rd[i];
    end
    nconf = 1'b0;
    for (int p = 0; p < NW; p++)
      for (int q = p + 1; q < NW; q++)
        if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW] &&
            (wr_be[p*NB +: NB] & wr_be[q*NB +: NB]) != '0)
          nconf = 1'b1;
    for (int p = 0; p < NW; p++) begin
      if (wr_en[p]) begin
        a = wr_addr[p*AW +: AW];
        w = mm[a];
        for (int b = 0; b < NB; b++)
          if (wr_be[p*NB + b]) w[b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
        mm[a] = w;
      end
    end
    for (int i = 0; i < NR; i++) exp_rd[i] = nexp[i];
    cyc();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rd_valid[%0d]", i), 64'(rd_valid[i]), 64'(nval[i]));
      chk($sformatf("rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(nexp[i]));
    end
    chk("wr_conflict", 64'(wr_conflict), 64'(nconf));
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      idle();
      if (n == 100) begin
        wr_en = 4'b0001; wr_addr[AW-1:0] = 10'h010; wr_data[DW-1:0] = 16'hFFFF; wr_be[1:0] = 2'b11;
        rd_en = 4'b1111; rd_addr = pa(10'h010, 10'h010, 10'h3FF, 10'h000);
      end
      cyc();
      n++;
      if (n == 101) chk({name, " rd_valid_in_clear"}, 64'(rd_valid), 64'(0));
    end
    idle();
    chk({name, " busy_cycles"}, 64'(n), 64'(1024));
  endtask

  task automatic add(input string nm, input logic [NW-1:0] we, input logic [NW*AW-1:0] wa,
                     input logic [NW*DW-1:0] wd, input logic [NW*NB-1:0] wbe,
                     input logic [NR-1:0] re, input logic [NR*AW-1:0] ra,
                     input logic [NR*DW-1:0] xd, input logic [NR-1:0] xv, input logic xc);
    vec_t v;
    v.name = nm; v.we = we; v.wa = wa; v.wd = wd; v.wbe = wbe;
    v.re = re; v.ra = ra; v.xd = xd; v.xv = xv; v.xc = xc;
    tbl.push_back(v);
  endtask

  initial begin
    localparam logic [15:0] C = 16'hABCD;
    add("wr5", 4'b0001, pa(0,0,0,5), pd(0,0,0,16'hABCD), 8'b00_00_00_11,
        4'b0000, '0, pd(0,0,0,0), 4'b0000, 1'b0);
    add("rd5x4", 4'b0000, '0, '0, '0,
        4'b1111, pa(5,5,5,5), pd(C,C,C,C), 4'b1111, 1'b0);
    add("wr7conf", 4'b1010, pa(7,0,7,0), pd(16'h2233,0,16'h1111,0), 8'b10_00_11_00,
        4'b0000, '0, pd(C,C,C,C), 4'b0000, 1'b1);
    add("rd7", 4'b0000, '0, '0, '0,
        4'b0001, pa(0,0,0,7), pd(C,C,C,16'h2211), 4'b0001, 1'b0);
    add("wr9rd9", 4'b0100, pa(0,9,0,0), pd(0,16'h5A5A,0,0), 8'b00_11_00_00,
        4'b0001, pa(0,0,0,9), pd(C,C,C,BYP9), 4'b0001, 1'b0);
    add("rd9", 4'b0000, '0, '0, '0,
        4'b0010, pa(0,0,9,0), pd(C,C,16'h5A5A,BYP9), 4'b0010, 1'b0);
    add("be0noop", 4'b0001, pa(0,0,0,5), pd(0,0,0,16'hFFFF), 8'b00_00_00_00,
        4'b0100, pa(0,5,0,0), pd(C,C,16'h5A5A,BYP9), 4'b0100, 1'b0);
    add("rd5after", 4'b0000, '0, '0, '0,
        4'b1000, pa(5,0,0,0), pd(C,C,16'h5A5A,BYP9), 4'b1000, 1'b0);
    add("disjoint_bytes", 4'b0011, pa(0,0,11,11), pd(0,0,16'hBB00,16'h00AA), 8'b00_00_10_01,
        4'b0000, '0, pd(C,C,16'h5A5A,BYP9), 4'b0000, 1'b0);
    add("rd11", 4'b0000, '0, '0, '0,
        4'b0001, pa(0,0,0,11), pd(C,C,16'h5A5A,16'hBBAA), 4'b0001, 1'b0);
    add("wr20all", 4'b1111, pa(20,20,20,20), pd(16'h4000,16'h3000,16'h2000,16'h1000),
        8'b11_11_11_11, 4'b1111, pa(20,20,20,20), pd(BYP20,BYP20,BYP20,BYP20), 4'b1111, 1'b1);
    add("rd20", 4'b0000, '0, '0, '0,
        4'b1111, pa(20,20,20,20), pd(16'h4000,16'h4000,16'h4000,16'h4000), 4'b1111, 1'b0);

    idle();
    reset = 1'b1;
    cyc(); cyc();
    chk("reset rd_data", 64'(rd_data), 64'(0));
    chk("reset rd_valid", 64'(rd_valid), 64'(0));
    chk("reset wr_conflict", 64'(wr_conflict), 64'(0));
    chk("reset busy", 64'(busy), 64'(1));
    reset = 1'b0;
    model_reset();
    wait_clear("clear1");
    chk("busy2 after clear", 64'(busy2), 64'(0));

    rd_en = 4'b0011; rd_addr = pa(0, 0, 10'h010, 10'h3FF);
    step();
    idle();

    foreach (tbl[k]) begin
      wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd; wr_be = tbl[k].wbe;
      rd_en = tbl[k].re; rd_addr = tbl[k].ra;
      step();
      chk({tbl[k].name, " rd_data"}, 64'(rd_data), 64'(tbl[k].xd));
      chk({tbl[k].name, " rd_valid"}, 64'(rd_valid), 64'(tbl[k].xv));
      chk({tbl[k].name, " wr_conflict"}, 64'(wr_conflict), 64'(tbl[k].xc));
    end
    idle();

    // 32-bit instance: partial byte write over an existing word
    wr_en2 = 2'b01; wr_addr2[9:0] = 10'd1; wr_data2[31:0] = 32'h12345678; wr_be2[3:0] = 4'b1111;
    cyc();
    idle();
    wr_en2 = 2'b10; wr_addr2[19:10] = 10'd1; wr_data2[63:32] = 32'h000000FF; wr_be2[7:4] = 4'b0001;
    cyc();
    idle();
    rd_en2 = 1'b1; rd_addr2 = 10'd1;
    cyc();
    idle();
    chk("w32 be merge rd_data", 64'(rd_data2), 64'(32'h123456FF));
    chk("w32 be merge rd_valid", 64'(rd_valid2), 64'(1));

    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NW; p++) begin
        wr_en[p] = 1'($urandom_range(0, 1));
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[p*DW +: DW] = 16'($urandom);
        wr_be[p*NB +: NB] = NB'($urandom_range(0, 3));
      end
      for (int i = 0; i < NR; i++) begin
        rd_en[i] = 1'($urandom_range(0, 1));
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      step();
    end
    idle();

    wr_en = 4'b0001; wr_addr = pa(0,0,0,3); wr_data = pd(0,0,0,16'hBEEF); wr_be = 8'b00_00_00_11;
    step();
    idle();
    rd_en = 4'b0001; rd_addr = pa(0,0,0,3);
    step();
    idle();

    reset = 1'b1;
    cyc();
    chk("rst2 rd_data", 64'(rd_data), 64'(0));
    chk("rst2 busy", 64'(busy), 64'(1));
    reset = 1'b0;
    model_reset();
    repeat (500) cyc();
    chk("busy at ptr500", 64'(busy), 64'(1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_clear("clear_restart");

    rd_en = 4'b0001; rd_addr = pa(0,0,0,3);
    step();
    chk("addr3 after clear", 64'(rd_data[15:0]), 64'(0));
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
